alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It takes two WIDTH-bit operands and a 3-bit opcode and returns a registered 2*WIDTH-bit result with status flags. Single-cycle ops complete in one clock; multiply is an iterative shift-add over WIDTH cycles. It sits between the datapath register file and the writeback mux, driven by a start/done handshake from the sequencer.

## Interface
- WIDTH, 8, operand width in bits (≥4); result width is 2*WIDTH
- SHW, $clog2(2*WIDTH), shift-amount width, derived; do not override

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- start  in  1  request; sampled only when busy=0
- s  in  3  opcode, captured with start
- a  in  WIDTH  operand A, captured with start
- b  in  WIDTH  operand B, captured with start
- y  out  2*WIDTH  registered result, held until the next done
- done  out  1  one-cycle pulse; y and flags are valid from this cycle onward
- busy  out  1  high while a multiply is in progress
- carry  out  1  add carry-out / sub borrow
- zero  out  1  y == 0
- ovf  out  1  signed overflow (add/sub only, else 0)

## Operation
- Opcodes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a, 110 mul (unsigned, multi-cycle), 111 shift-left a by b[SHW-1:0].
- Add: y = zero-extended {carry, a+b}; carry = bit WIDTH of the sum.
- Sub: y[WIDTH-1:0] = a-b mod 2^WIDTH, upper bits 0; carry = 1 iff a<b (unsigned).
- ovf: signed two's-complement overflow of add/sub; 0 for every other op.
- Logic ops and not: result in y[WIDTH-1:0], upper bits 0, carry=0.
- Shift: y = a zero-extended to 2*WIDTH, shifted left by b[SHW-1:0]; bits shifted past bit 2*WIDTH-1 are lost; carry=0.
- Mul: y = a*b (full 2*WIDTH product); carry=0.
- zero is computed on the final y for every op.
- FSM states:
  - IDLE → MUL on start with s=110.
  - IDLE → IDLE on any other start; result is written that edge.
  - MUL → IDLE when the iteration counter reaches WIDTH-1; product is written that edge.
- MUL holds the captured operands, a 2*WIDTH accumulator and a counter. Each cycle it adds the shifted multiplicand when the current multiplier bit is 1.

## Timing
- Reset: state IDLE; y=0, done=0, busy=0, carry=0, zero=0, ovf=0; counter and accumulator cleared.
- Reset asserted mid-multiply aborts immediately. No done is produced for the aborted op.
- Non-mul, start accepted in cycle N:
  - y, flags and done=1 appear after the edge ending cycle N.
  - done falls after one cycle.
  - busy is never asserted.
- Mul, start accepted in cycle N:
  - busy=1 for cycles N+1..N+WIDTH.
  - done=1 and busy=0 in cycle N+WIDTH+1, with y and flags valid.
  - Latency is WIDTH+1 edges.
- start with busy=1 is ignored. The operands and opcode in flight are unaffected.
- Back-to-back: start may be asserted in the same cycle done is high. It is accepted, giving 1 result per cycle for non-mul ops.
- Between results y and the flags hold their values. They do not change while a multiply is in progress.

## Configuration
- ALU_SAT_EN defined: add and sub saturate unsigned.
  - Add with carry=1 gives y = {WIDTH zeros, WIDTH ones}.
  - Sub with borrow gives y = 0.
  - carry and ovf still report the unsaturated condition; zero follows the saturated y.
- ALU_SAT_EN undefined: add and sub wrap as described in Operation.
- No other op is affected.

## Test plan
All scenarios use WIDTH=8, a=0xD9, b=0x97 unless noted.
- Sweep s=000..101, one start per cycle back-to-back. Expect, in order:
  - add: y=0x0170, carry=1, ovf=1 (0x0170 without ALU_SAT_EN; 0x00FF with it)
  - sub: y=0x0042, carry=0, ovf=0
  - and: y=0x0091
  - or: y=0x00DF
  - xor: y=0x004E
  - not a: y=0x0026
  - done high in each following cycle.
- s=110 → busy high 8 cycles; done after 9 edges with y=0x7FFF. Pulse start with s=000 during busy → ignored; y stays 0x7FFF.
- s=111 (b[3:0]=7) → y=0x6C80. Then a=0xFF, b=0x0F → y=0x8000.
- a=b=0x55, s=001 → y=0x0000, zero=1, carry=0. Then a=0x00, b=0x01 → y=0x00FF and carry=1 (y=0x0000, zero=1 with ALU_SAT_EN).
- Start mul, drop rst_n in the 4th busy cycle → all outputs 0 immediately. After release, no done pulse. A new add (0x01+0x02) gives y=0x0003 next cycle.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle between the sequencer and alu_seq.
// master = sequencer side, slave = ALU side.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic                 start;
  logic [2:0]           s;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   y;
  logic                 done;
  logic                 busy;
  logic                 carry;
  logic                 zero;
  logic                 ovf;

  modport master (
    output start, s, a, b,
    input  y, done, busy, carry, zero, ovf
  );

  modport slave (
    input  start, s, a, b,
    output y, done, busy, carry, zero, ovf
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply.
// Define ALU_SAT_EN for unsigned-saturating add/sub.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(2 * WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpNot = 3'b101;
  localparam logic [2:0] OpMul = 3'b110;
  localparam logic [2:0] OpShl = 3'b111;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   y_q, y_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]  sum, diff;
  logic [RW-1:0]   res;
  logic            res_carry, res_ovf;
  logic [RW-1:0]   acc_next;

  // Single-cycle result for the opcode currently on the bus.
  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} - {1'b0, bus.b};
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    unique case (bus.s)
      OpAdd: begin
        res_carry = sum[WIDTH];
        res_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
`ifdef ALU_SAT_EN
        res       = sum[WIDTH] ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
`else
        res       = {{(WIDTH-1){1'b0}}, sum};
`endif
      end
      OpSub: begin
        res_carry = diff[WIDTH];
        res_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
`ifdef ALU_SAT_EN
        res       = diff[WIDTH] ? '0 : {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
`else
        res       = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
`endif
      end
      OpAnd: res = {{WIDTH{1'b0}}, bus.a & bus.b};
      OpOr:  res = {{WIDTH{1'b0}}, bus.a | bus.b};
      OpXor: res = {{WIDTH{1'b0}}, bus.a ^ bus.b};
      OpNot: res = {{WIDTH{1'b0}}, ~bus.a};
      OpMul: res = '0;
      OpShl: res = {{WIDTH{1'b0}}, bus.a} << bus.b[SHW-1:0];
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.s == OpMul) begin
            state_d  = StMul;
            busy_d   = 1'b1;
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            done_d  = 1'b1;
            y_d     = res;
            carry_d = res_carry;
            ovf_d   = res_ovf;
            zero_d  = (res == '0);
          end
        end
      end
      StMul: begin
        // One multiplier bit per cycle; start is ignored until back in idle.
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          y_d     = acc_next;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = (acc_next == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      y_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table plus multiply, busy-ignore
// and reset-abort sequences. Expectations follow ALU_SAT_EN when defined.
module tb_alu_seq;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
    logic        c;
    logic        z;
    logic        o;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

`ifdef ALU_SAT_EN
  localparam logic [15:0] AddOvY  = 16'h00FF;
  localparam logic [15:0] AddFfY  = 16'h00FF;
  localparam logic [15:0] SubBorY = 16'h0000;
  localparam logic        SubBorZ = 1'b1;
`else
  localparam logic [15:0] AddOvY  = 16'h0170;
  localparam logic [15:0] AddFfY  = 16'h0100;
  localparam logic [15:0] SubBorY = 16'h00FF;
  localparam logic        SubBorZ = 1'b0;
`endif

  logic [15:0] prev_y;

  initial begin
    bus.start = 1'b0;
    bus.s     = 3'd0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;

    //           s     a      b      y        c     z        o
    vecs[0]  = '{3'd0, 8'hD9, 8'h97, AddOvY,  1'b1, 1'b0,    1'b1};
    vecs[1]  = '{3'd1, 8'hD9, 8'h97, 16'h0042, 1'b0, 1'b0,   1'b0};
    vecs[2]  = '{3'd2, 8'hD9, 8'h97, 16'h0091, 1'b0, 1'b0,   1'b0};
    vecs[3]  = '{3'd3, 8'hD9, 8'h97, 16'h00DF, 1'b0, 1'b0,   1'b0};
    vecs[4]  = '{3'd4, 8'hD9, 8'h97, 16'h004E, 1'b0, 1'b0,   1'b0};
    vecs[5]  = '{3'd5, 8'hD9, 8'h97, 16'h0026, 1'b0, 1'b0,   1'b0};
    vecs[6]  = '{3'd1, 8'h55, 8'h55, 16'h0000, 1'b0, 1'b1,   1'b0};
    vecs[7]  = '{3'd1, 8'h00, 8'h01, SubBorY, 1'b1, SubBorZ, 1'b0};
    vecs[8]  = '{3'd0, 8'hFF, 8'h01, AddFfY,  1'b1, 1'b0,    1'b0};
    vecs[9]  = '{3'd0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1,   1'b0};
    vecs[10] = '{3'd7, 8'hFF, 8'h0F, 16'h8000, 1'b0, 1'b0,   1'b0};
    vecs[11] = '{3'd7, 8'hD9, 8'h97, 16'h6C80, 1'b0, 1'b0,   1'b0};

    // Reset state
    #12;
    chk("rst_y", 32'(bus.y), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_carry", 32'(bus.carry), 32'h0);
    chk("rst_zero", 32'(bus.zero), 32'h0);
    chk("rst_ovf", 32'(bus.ovf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Back-to-back table, start held high throughout
    for (int i = 0; i < NV; i++) begin
      bus.start = 1'b1;
      bus.s     = vecs[i].s;
      bus.a     = vecs[i].a;
      bus.b     = vecs[i].b;
      tick();
      chk($sformatf("v%0d_y", i), 32'(bus.y), 32'(vecs[i].y));
      chk($sformatf("v%0d_carry", i), 32'(bus.carry), 32'(vecs[i].c));
      chk($sformatf("v%0d_zero", i), 32'(bus.zero), 32'(vecs[i].z));
      chk($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].o));
      chk($sformatf("v%0d_done", i), 32'(bus.done), 32'h1);
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'h0);
    end
    bus.start = 1'b0;
    tick();
    chk("idle_done", 32'(bus.done), 32'h0);
    chk("idle_y_hold", 32'(bus.y), 32'(vecs[NV-1].y));
    prev_y = vecs[NV-1].y;

    // Multiply with an ignored start during busy
    bus.start = 1'b1;
    bus.s     = 3'd6;
    bus.a     = 8'hD9;
    bus.b     = 8'h97;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("mul_busy%0d", i), 32'(bus.busy), 32'h1);
      chk($sformatf("mul_done%0d", i), 32'(bus.done), 32'h0);
      chk($sformatf("mul_yhold%0d", i), 32'(bus.y), 32'(prev_y));
      if (i == 3) begin
        bus.start = 1'b1;
        bus.s     = 3'd0;
        bus.a     = 8'h01;
        bus.b     = 8'h02;
      end
      if (i == 4) bus.start = 1'b0;
      tick();
    end
    chk("mul_done", 32'(bus.done), 32'h1);
    chk("mul_busy_end", 32'(bus.busy), 32'h0);
    chk("mul_y", 32'(bus.y), 32'h7FFF);
    chk("mul_carry", 32'(bus.carry), 32'h0);
    chk("mul_zero", 32'(bus.zero), 32'h0);
    chk("mul_ovf", 32'(bus.ovf), 32'h0);
    tick();
    chk("mul_done_fall", 32'(bus.done), 32'h0);
    chk("mul_y_after", 32'(bus.y), 32'h7FFF);

    // Reset in the 4th busy cycle aborts the multiply
    bus.start = 1'b1;
    bus.s     = 3'd6;
    bus.a     = 8'hD9;
    bus.b     = 8'h97;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy_pre", 32'(bus.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_y", 32'(bus.y), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    chk("abort_flags", 32'({bus.carry, bus.zero, bus.ovf}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("abort_nodone%0d", i), 32'({bus.done, bus.busy}), 32'h0);
    end

    bus.start = 1'b1;
    bus.s     = 3'd0;
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    tick();
    bus.start = 1'b0;
    chk("post_add_y", 32'(bus.y), 32'h0003);
    chk("post_add_done", 32'(bus.done), 32'h1);
    chk("post_add_flags", 32'({bus.carry, bus.zero, bus.ovf}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
